seq_control_unit: RTL and testbench

SEQ_CONTROL_UNIT -- requirements
Module: seq_control_unit

---
 rtl/seq_control_unit.sv | 177 +++++++++++++++++
 tb/tb_seq_control_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seq_control_unit.sv
// Sequencer for a multi-cycle register-transfer processor: fetch in IDLE, then 1 (moves) or 3 (ALU) execute steps.
// Outputs are combinational from state/IR/run/g_zero; no backpressure, and run is only sampled in IDLE.
module seq_control_unit #(
  parameter int DATA_W = 16,
  parameter int N_REGS = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              run,
  input  logic [DATA_W-1:0] din,
  input  logic              g_zero,
  output logic              IRin,
  output logic              DINout,
  output logic              Ain,
  output logic              Gin,
  output logic              Gout,
  output logic [N_REGS-1:0] Rout,
  output logic [N_REGS-1:0] Rin,
  output logic [2:0]        alu_op,
  output logic              done,
  output logic              busy,
  output logic              illegal
);

  localparam int RB   = $clog2(N_REGS);
  localparam int IR_W = 4 + 2 * RB;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MV   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_MVI  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_MVNZ = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IR_W-1:0]   ir_q, ir_d;

  logic [3:0]        opcode;
  logic [RB-1:0]     rx_idx, ry_idx;
  logic [N_REGS-1:0] rx_oh, ry_oh;
  logic [2:0]        alu_sel;

  assign opcode = ir_q[IR_W-1 -: 4];
  assign rx_idx = ir_q[2*RB-1:RB];
  assign ry_idx = ir_q[RB-1:0];
  assign rx_oh  = N_REGS'(1) << rx_idx;
  assign ry_oh  = N_REGS'(1) << ry_idx;

  // Upper din bits carry immediates for the datapath only; the sequencer never looks at them.
  if (DATA_W > IR_W) begin : g_din_hi
    logic unused_din_hi;
    assign unused_din_hi = ^din[DATA_W-1:IR_W];
  end

  always_comb begin
    alu_sel = 3'd0;
    case (opcode)
      OP_ADD:  alu_sel = 3'd1;
      OP_SUB:  alu_sel = 3'd2;
      OP_AND:  alu_sel = 3'd3;
      OP_OR:   alu_sel = 3'd4;
      default: alu_sel = 3'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    IRin    = 1'b0;
    DINout  = 1'b0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    Gout    = 1'b0;
    Rout    = '0;
    Rin     = '0;
    alu_op  = 3'd0;
    done    = 1'b0;
    busy    = 1'b0;
    illegal = 1'b0;

    case (state_q)
      S_IDLE: begin
        IRin = run;
        if (run) begin
          ir_d    = din[IR_W-1:0];
          state_d = S_T1;
        end
      end
      S_T1: begin
        busy    = 1'b1;
        state_d = S_IDLE;
        case (opcode)
          OP_NOP: done = 1'b1;
          OP_MV: begin
            Rout = ry_oh;
            Rin  = rx_oh;
            done = 1'b1;
          end
          OP_MVI: begin
            DINout = 1'b1;
            Rin    = rx_oh;
            done   = 1'b1;
          end
          OP_MVNZ: begin
            if (!g_zero) begin
              Rout = ry_oh;
              Rin  = rx_oh;
            end
            done = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            Rout    = rx_oh;
            Ain     = 1'b1;
            state_d = S_T2;
          end
          default: begin
            done    = 1'b1;
            illegal = 1'b1;
          end
        endcase
      end
      S_T2: begin
        busy    = 1'b1;
        Rout    = ry_oh;
        alu_op  = alu_sel;
        Gin     = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        busy    = 1'b1;
        Gout    = 1'b1;
        Rin     = rx_oh;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // IDLE decode would otherwise echo run onto IRin while reset is held.
    if (!resetn) begin
      IRin    = 1'b0;
      DINout  = 1'b0;
      Ain     = 1'b0;
      Gin     = 1'b0;
      Gout    = 1'b0;
      Rout    = '0;
      Rin     = '0;
      alu_op  = 3'd0;
      done    = 1'b0;
      busy    = 1'b0;
      illegal = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  a_single_bus_driver: assert property (@(posedge clock) disable iff (!resetn)
    $onehot0({Gout, DINout, |Rout}));

endmodule

// File: tb/tb_seq_control_unit.sv
// Table-driven check of seq_control_unit with a scoreboard of per-cycle expected strobes.
module tb_seq_control_unit;

  typedef struct packed {
    logic       irin;
    logic       dinout;
    logic       ain;
    logic       gin;
    logic       gout;
    logic [7:0] rout;
    logic [7:0] rin;
    logic [2:0] alu;
    logic       done;
    logic       busy;
    logic       illegal;
  } outs_t;

  typedef struct {
    string       name;
    logic [15:0] din;
    logic        g_zero;
    logic        run_hold;
    int          nsteps;
    outs_t       st [3];
  } vec_t;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        run = 1'b0;
  logic [15:0] din = '0;
  logic        g_zero = 1'b0;
  logic        IRin, DINout, Ain, Gin, Gout, done, busy, illegal;
  logic [7:0]  Rout, Rin;
  logic [2:0]  alu_op;

  outs_t act;
  outs_t sb [$];
  vec_t  tbl [$];
  int    total = 0;
  int    bad = 0;

  localparam outs_t ZERO  = '0;
  localparam outs_t FETCH = 27'h4000000;

  seq_control_unit #(.DATA_W(16), .N_REGS(8)) dut (
    .clock(clock), .resetn(resetn), .run(run), .din(din), .g_zero(g_zero),
    .IRin(IRin), .DINout(DINout), .Ain(Ain), .Gin(Gin), .Gout(Gout),
    .Rout(Rout), .Rin(Rin), .alu_op(alu_op),
    .done(done), .busy(busy), .illegal(illegal)
  );

  always #5 clock = ~clock;

  assign act = '{irin: IRin, dinout: DINout, ain: Ain, gin: Gin, gout: Gout,
                 rout: Rout, rin: Rin, alu: alu_op, done: done, busy: busy, illegal: illegal};

  // Expected execute-step outputs (busy is always 1 outside IDLE).
  function automatic outs_t ex(input logic [7:0] rout, input logic [7:0] rin,
                               input logic ain, input logic gin, input logic gout,
                               input logic dinout, input logic [2:0] alu,
                               input logic dn, input logic ill);
    outs_t o;
    o = '0;
    o.rout = rout; o.rin = rin; o.ain = ain; o.gin = gin; o.gout = gout;
    o.dinout = dinout; o.alu = alu; o.done = dn; o.illegal = ill; o.busy = 1'b1;
    return o;
  endfunction

  task automatic add_vec(input string nm, input logic [15:0] d, input logic g,
                         input logic rh, input int n, input outs_t a, input outs_t b, input outs_t c);
    vec_t v;
    v.name = nm; v.din = d; v.g_zero = g; v.run_hold = rh; v.nsteps = n;
    v.st[0] = a; v.st[1] = b; v.st[2] = c;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm);
    outs_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, got %h", nm, act);
    end else begin
      e = sb.pop_front();
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got %h want %h", nm, act, e);
      end
    end
  endtask

  task automatic chk_now(input outs_t e, input string nm);
    sb.push_back(e);
    check(nm);
  endtask

  task automatic cyc(input logic r, input logic [15:0] d, input logic g, input outs_t e, input string nm);
    @(posedge clock);
    #1;
    run = r; din = d; g_zero = g;
    sb.push_back(e);
    @(negedge clock);
    check(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //       name        din       g  rh n  T1                                              T2                                    T3
    add_vec("mv_r2_r5",  16'h0055, 0, 1, 1, ex(8'h20, 8'h04, 0, 0, 0, 0, 3'd0, 1, 0), ZERO, ZERO);
    add_vec("add_r1_r3", 16'h008B, 0, 0, 3, ex(8'h02, 8'h00, 1, 0, 0, 0, 3'd0, 0, 0),
                                            ex(8'h08, 8'h00, 0, 1, 0, 0, 3'd1, 0, 0),
                                            ex(8'h00, 8'h02, 0, 0, 1, 0, 3'd0, 1, 0));
    add_vec("mvi_r7",    16'h0138, 0, 0, 1, ex(8'h00, 8'h80, 0, 0, 0, 1, 3'd0, 1, 0), ZERO, ZERO);
    add_vec("mvnz_gz1",  16'h01C1, 1, 1, 1, ex(8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 1, 0), ZERO, ZERO);
    add_vec("mvnz_gz0",  16'h01C1, 0, 0, 1, ex(8'h02, 8'h01, 0, 0, 0, 0, 3'd0, 1, 0), ZERO, ZERO);
    add_vec("illegal_f", 16'h03C0, 0, 1, 1, ex(8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 1, 1), ZERO, ZERO);
    add_vec("nop_hi",    16'hF000, 1, 0, 1, ex(8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 1, 0), ZERO, ZERO);
    add_vec("sub_r4_r6", 16'h00E6, 1, 1, 3, ex(8'h10, 8'h00, 1, 0, 0, 0, 3'd0, 0, 0),
                                            ex(8'h40, 8'h00, 0, 1, 0, 0, 3'd2, 0, 0),
                                            ex(8'h00, 8'h10, 0, 0, 1, 0, 3'd0, 1, 0));
    add_vec("and_r5_r2", 16'h016A, 0, 0, 3, ex(8'h20, 8'h00, 1, 0, 0, 0, 3'd0, 0, 0),
                                            ex(8'h04, 8'h00, 0, 1, 0, 0, 3'd3, 0, 0),
                                            ex(8'h00, 8'h20, 0, 0, 1, 0, 3'd0, 1, 0));
    add_vec("or_r0_r7",  16'h0187, 0, 1, 3, ex(8'h01, 8'h00, 1, 0, 0, 0, 3'd0, 0, 0),
                                            ex(8'h80, 8'h00, 0, 1, 0, 0, 3'd4, 0, 0),
                                            ex(8'h00, 8'h01, 0, 0, 1, 0, 3'd0, 1, 0));
    add_vec("mv_r3_r3",  16'h005B, 0, 0, 1, ex(8'h08, 8'h08, 0, 0, 0, 0, 3'd0, 1, 0), ZERO, ZERO);
    add_vec("illegal_8", 16'h0200, 0, 0, 1, ex(8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 1, 1), ZERO, ZERO);

    // Reset held with run high: everything, including IRin, stays low.
    run = 1'b1; din = 16'h0055;
    #1;
    chk_now(ZERO, "reset_async");
    @(negedge clock);
    chk_now(ZERO, "reset_held");
    #1;
    run = 1'b0;
    resetn = 1'b1;
    @(negedge clock);
    chk_now(ZERO, "idle_after_reset");

    foreach (tbl[i]) begin
      cyc(1'b1, tbl[i].din, tbl[i].g_zero, FETCH, {tbl[i].name, "_fetch"});
      for (int s = 0; s < tbl[i].nsteps; s++)
        cyc(tbl[i].run_hold, 16'hFFFF, tbl[i].g_zero, tbl[i].st[s], {tbl[i].name, "_step"});
      cyc(1'b0, 16'h0000, tbl[i].g_zero, ZERO, {tbl[i].name, "_idle"});
    end

    // run held high across done: exactly one IDLE fetch cycle before the next instruction.
    cyc(1'b1, 16'h0055, 1'b0, FETCH, "b2b_fetch1");
    cyc(1'b1, 16'h0138, 1'b0, ex(8'h20, 8'h04, 0, 0, 0, 0, 3'd0, 1, 0), "b2b_mv");
    cyc(1'b1, 16'h0138, 1'b0, FETCH, "b2b_fetch2");
    cyc(1'b0, 16'h0000, 1'b0, ex(8'h00, 8'h80, 0, 0, 0, 1, 3'd0, 1, 0), "b2b_mvi");
    cyc(1'b0, 16'h0000, 1'b0, ZERO, "b2b_idle");

    // Reset in T2 of SUB: outputs drop in the same cycle, no done, clean refetch afterwards.
    cyc(1'b1, 16'h00E6, 1'b0, FETCH, "rst_sub_fetch");
    cyc(1'b1, 16'h00E6, 1'b0, ex(8'h10, 8'h00, 1, 0, 0, 0, 3'd0, 0, 0), "rst_sub_t1");
    cyc(1'b1, 16'h00E6, 1'b0, ex(8'h40, 8'h00, 0, 1, 0, 0, 3'd2, 0, 0), "rst_sub_t2");
    #1;
    resetn = 1'b0;
    #1;
    chk_now(ZERO, "rst_mid_t2");
    @(negedge clock);
    chk_now(ZERO, "rst_mid_held");
    #1;
    din = 16'h0055;
    resetn = 1'b1;
    #1;
    chk_now(FETCH, "post_rst_fetch");
    cyc(1'b0, 16'h0000, 1'b0, ex(8'h20, 8'h04, 0, 0, 0, 0, 3'd0, 1, 0), "post_rst_mv");
    cyc(1'b0, 16'h0000, 1'b0, ZERO, "post_rst_idle");

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: left=%0d want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
